// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD command path: FSM encoding,
// frame constants, common command numbers and the serial CRC7 step.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    SEND    = 3'd2,
    HANDOFF = 3'd3,
    WAIT    = 3'd4,
    DONE    = 3'd5
  } sd_state_e;

  localparam logic [1:0] SD_START_BITS  = 2'b01;
  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam logic [7:0] R1_TIMEOUT_VAL = 8'hFF;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  // One serial step of CRC7 (x^7 + x^3 + 1), data bit fed MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator. clr zeroes the register, en folds in one bit.
// Also used by the data path, so it knows nothing about command frames.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  // Next CRC value: clear has priority over an update.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 7'h00;
    end else if (en) begin
      crc_d = crc7_step(crc_q, din);
    end
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// SPI-mode SD command transmitter. Sends optional 0xFF fill bytes and a
// 48-bit command frame on DI (MSB first, CRC7 computed on the fly), kicks
// the R1 parser with rp_start and returns its byte, or 0xFF plus timeout
// if the parser does not finish within TIMEOUT_CYC cycles.
//
// Handshake: start is a request sampled only in IDLE (no valid/ready
// back-pressure, no queuing); busy is high from the cycle after acceptance
// until done; done is a one-cycle pulse qualifying response and timeout,
// which are then held until the next accepted request.
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int PRE_BYTES   = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] arg,
  output logic        DI,
  output logic        busy,
  output logic        done,
  output logic [7:0]  response,
  output logic        timeout,
  output logic        rp_start,
  input  logic        rp_finish,
  input  logic [7:0]  rp_response,
  output sd_state_e   dbg_state
);

  localparam int FILL_CYC = PRE_BYTES * 8;
  localparam int FILL_W   = (FILL_CYC > 1) ? $clog2(FILL_CYC) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((FILL_CYC > 0) ? FILL_CYC - 1 : 0);
  // The counter is 0 in the first WAIT cycle; the exit decision is taken
  // in the cycle whose increment would make it reach TIMEOUT_CYC-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC >= 2) ? TIMEOUT_CYC - 2 : 0);

  sd_state_e         state_q, state_d;
  logic [39:0]       hdr_q, hdr_d;        // start bits, index, argument
  logic [5:0]        bit_cnt_q, bit_cnt_d; // frame bit currently on DI
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        response_q, response_d;
  logic              timeout_q, timeout_d;

  logic              accept;
  logic              crc_clr;
  logic              crc_en;
  logic [6:0]        crc;
  logic [2:0]        crc_sel;

  assign accept  = (state_q == IDLE) && start;
  assign crc_clr = accept;
  // Only the 40 header bits (frame bits 47..8) feed the CRC.
  assign crc_en  = (state_q == SEND) && (bit_cnt_q >= 6'd8);
  // Frame bits 7..1 carry crc[6..0].
  assign crc_sel = bit_cnt_q[2:0] - 3'd1;

  sd_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (hdr_q[39]),
    .crc (crc)
  );

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (PRE_BYTES == 0) ? SEND : FILL;
      FILL:    if (fill_cnt_q == FILL_LAST) state_d = SEND;
      SEND:    if (bit_cnt_q == 6'd0) state_d = HANDOFF;
      HANDOFF: state_d = WAIT;
      WAIT:    if (rp_finish || (to_cnt_q == TO_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latching, counters and result capture.
  always_comb begin
    hdr_d      = hdr_q;
    bit_cnt_d  = bit_cnt_q;
    fill_cnt_d = fill_cnt_q;
    to_cnt_d   = to_cnt_q;
    response_d = response_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          hdr_d      = {SD_START_BITS, cmd_index, arg};
          bit_cnt_d  = 6'd47;
          fill_cnt_d = '0;
          timeout_d  = 1'b0;
        end
      end
      FILL: begin
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
      end
      SEND: begin
        bit_cnt_d = bit_cnt_q - 6'd1;
        if (bit_cnt_q >= 6'd8) begin
          hdr_d = {hdr_q[38:0], 1'b0};
        end
      end
      HANDOFF: begin
        to_cnt_d = '0;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rp_finish) begin
          response_d = rp_response;
          timeout_d  = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          response_d = R1_TIMEOUT_VAL;
          timeout_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q      <= '0;
      bit_cnt_q  <= '0;
      fill_cnt_q <= '0;
      to_cnt_q   <= '0;
      response_q <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      hdr_q      <= hdr_d;
      bit_cnt_q  <= bit_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      to_cnt_q   <= to_cnt_d;
      response_q <= response_d;
      timeout_q  <= timeout_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    DI       = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    rp_start = 1'b0;
    case (state_q)
      FILL: begin
        busy = 1'b1;
      end
      SEND: begin
        busy = 1'b1;
        if (bit_cnt_q >= 6'd8) begin
          DI = hdr_q[39];
        end else if (bit_cnt_q != 6'd0) begin
          DI = crc[crc_sel];
        end
      end
      HANDOFF: begin
        busy     = 1'b1;
        rp_start = 1'b1;
      end
      WAIT: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign response  = response_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: directed command frames with hand-computed bytes,
// a parser model, and a scoreboard checking DI/rp_start/busy per cycle
// and the done result (cycle, response, timeout).
module tb_sd_cmd_tx;
  import sd_pkg::*;

  localparam int PRE_BYTES   = 1;
  localparam int TIMEOUT_CYC = 16;
  localparam int TO_W        = 5;

  // Hand-computed frames: index byte, 4 argument bytes, {CRC7,1}.
  localparam logic [47:0] F_CMD0   = 48'h40_00000000_95;
  localparam logic [47:0] F_CMD8   = 48'h48_000001AA_87;
  localparam logic [47:0] F_CMD58  = 48'h7A_00000000_FD;
  localparam logic [47:0] F_CMD55  = 48'h77_00000000_65;
  localparam logic [47:0] F_ACMD41 = 48'h69_40000000_77;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] arg;
  logic        DI;
  logic        busy;
  logic        done;
  logic [7:0]  response;
  logic        timeout;
  logic        rp_start;
  logic        rp_finish;
  logic [7:0]  rp_response;
  sd_state_e   dbg_state;

  sd_cmd_tx #(
    .PRE_BYTES   (PRE_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmd_index   (cmd_index),
    .arg         (arg),
    .DI          (DI),
    .busy        (busy),
    .done        (done),
    .response    (response),
    .timeout     (timeout),
    .rp_start    (rp_start),
    .rp_finish   (rp_finish),
    .rp_response (rp_response),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  exp_q[$];          // {DI, rp_start, busy} per cycle
  int          exp_done_cyc_q[$];
  logic [8:0]  exp_resp_q[$];     // {timeout, response}
  int          par_lat_q[$];
  logic [7:0]  par_val_q[$];
  int          next_free = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one command once the previous one is expected to be idle and
  // pushes the expected per-cycle DI/rp_start/busy sequence. n_push=58
  // covers fill, frame, handoff and the first wait cycle; a shorter
  // n_push is used when the frame is cut by reset. lat<0 means the
  // parser never finishes.
  task automatic issue(input logic [47:0] frame, input int lat, input logic [7:0] val,
                       input bit hold, input int n_push, output int c0);
    int dcyc;
    @(negedge clk);
    while (cyc < next_free) @(negedge clk);
    cmd_index = frame[45:40];
    arg       = frame[39:8];
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    c0 = cyc;
    for (int k = 0; k < n_push; k++) begin
      if (k < PRE_BYTES * 8)       exp_q.push_back(3'b101);
      else if (k < 56)             exp_q.push_back({frame[55-k], 2'b01});
      else if (k == 56)            exp_q.push_back(3'b111);
      else                         exp_q.push_back(3'b101);
    end
    if (n_push == 58) begin
      par_lat_q.push_back(lat);
      par_val_q.push_back(val);
      if (lat < 0) begin
        dcyc = c0 + 56 + TIMEOUT_CYC;
        exp_resp_q.push_back({1'b1, 8'hFF});
      end else begin
        dcyc = c0 + 57 + lat;
        exp_resp_q.push_back({1'b0, val});
      end
      exp_done_cyc_q.push_back(dcyc);
      next_free = dcyc + 1;
    end
  endtask

  task automatic wait_free();
    @(negedge clk);
    while (cyc < next_free) @(negedge clk);
  endtask

  // ---------------- parser model ----------------
  initial begin
    int         lat;
    logic [7:0] val;
    rp_finish   = 1'b0;
    rp_response = 8'h5A;
    forever begin
      @(negedge clk);
      if (rp_start === 1'b1) begin
        if (par_lat_q.size() == 0) begin
          check("rp_start_unexpected", rp_start, 0);
        end else begin
          lat = par_lat_q.pop_front();
          val = par_val_q.pop_front();
          if (lat >= 0) begin
            repeat (lat) @(negedge clk);
            rp_response = val;
            rp_finish   = 1'b1;
            @(negedge clk);
            rp_finish   = 1'b0;
            rp_response = 8'h5A;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [2:0] rec;
    int         ecyc;
    logic [8:0] eres;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        check("di_rpstart_busy", {DI, rp_start, busy}, rec);
      end
      if (done === 1'b1) begin
        if (exp_resp_q.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          ecyc = exp_done_cyc_q.pop_front();
          eres = exp_resp_q.pop_front();
          check("done_cycle", cyc, ecyc);
          check("timeout_response", {timeout, response}, eres);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    int nb;
    rst       = 1'b1;
    start     = 1'b0;
    cmd_index = 6'd0;
    arg       = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_di", DI, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rp_start", rp_start, 0);
    check("rst_response", response, 8'h00);
    check("rst_timeout", timeout, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    next_free = cyc + 1;

    // CMD0, parser answers 0x01.
    issue(F_CMD0, 2, 8'h01, 1'b0, 58, c0);
    // CMD8 with 0x1AA, CRC7 0x43.
    issue(F_CMD8, 4, 8'h01, 1'b0, 58, c0);
    // Parser never finishes: timeout.
    issue(F_CMD58, -1, 8'h00, 1'b0, 58, c0);
    // Parser finishes on the final wait cycle: no timeout.
    issue(F_CMD55, TIMEOUT_CYC - 1, 8'h01, 1'b0, 58, c0);

    // start pulsed mid-SEND with other inputs: ignored, frame unchanged.
    issue(F_CMD58, 3, 8'h00, 1'b0, 58, c0);
    while (cyc < c0 + 20) @(negedge clk);
    cmd_index = CMD8;
    arg       = 32'hDEADBEEF;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_free();
    nb = 0;
    repeat (70) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    check("no_second_frame", nb, 0);

    // Reset while frame bit 20 is on DI.
    issue(F_CMD8, 0, 8'h00, 1'b0, 36, c0);
    while (cyc < c0 + 35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_di", DI, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rp_start", rp_start, 0);
    check("midrst_state", dbg_state, IDLE);
    rst = 1'b0;
    next_free = cyc + 1;
    issue(F_CMD0, 1, 8'h01, 1'b0, 58, c0);

    // Back-to-back with start held high.
    issue(F_CMD55, 2, 8'h01, 1'b1, 58, c0);
    issue(F_ACMD41, 4, 8'h00, 1'b1, 58, c0);
    issue(F_CMD55, 3, 8'h05, 1'b0, 58, c0);

    wait_free();
    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", exp_resp_q.size(), 0);
    check("parser_q_drained", par_lat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
- SPI-mode SD command transmitter. It sits directly upstream of the R1 response parser.
- It serialises a 48-bit command frame onto DI, one bit per clk, MSB first, and computes CRC7 on the fly.
- After the frame, it pulses the parser's isStart and waits for the parser's isFinish.
- It then returns the captured R1 byte to the SD controller FSM with a done pulse, or a timeout flag if the parser does not finish in time.

Parameters:
- PRE_BYTES, default 1: number of 0xFF fill bytes driven on DI before each frame (0 allowed).
- TIMEOUT_CYC, default 1024: maximum cycles to wait for rp_finish after rp_start.
- TO_W, default 11: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; also the SPI bit clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to send a command; sampled only in IDLE.
- cmd_index  in  6  SD command number (CMD0..CMD63).
- arg  in  32  command argument.
- DI  out  1  serial data to the card (MOSI).
- busy  out  1  high from the cycle after start is accepted until done is pulsed.
- done  out  1  one-cycle pulse: response and timeout are valid.
- response  out  8  R1 byte, held until the next accepted start.
- timeout  out  1  set with done if rp_finish never arrived; held with response.
- rp_start  out  1  one-cycle pulse to the parser's isStart.
- rp_finish  in  1  the parser's isFinish.
- rp_response  in  8  the parser's response.

Behaviour:
- Reset values: DI=1, busy=0, done=0, rp_start=0, response=8'h00, timeout=0, state=IDLE. Reset applies in any state, mid-frame included; the current frame is abandoned.
- Frame layout, 48 bits, MSB first:
  - bits 47:46 = 2'b01
  - bits 45:40 = cmd_index
  - bits 39:8 = arg
  - bits 7:1 = CRC7
  - bit 0 = 1
- CRC7: generator x^7+x^3+1, register initialised to 0. Updated serially with each of the first 40 transmitted bits. Its 7 bits are emitted MSB first immediately after bit 8.
- cmd_index and arg are latched on acceptance; later changes are ignored.
- IDLE:
  - DI=1.
  - start=1 accepts the request: latch the inputs, set busy=1, clear timeout. Go to FILL, or to SEND if PRE_BYTES=0.
  - done deasserts the cycle after its pulse.
- FILL: DI=1 for PRE_BYTES*8 cycles, then SEND.
- SEND:
  - One frame bit per cycle, 48 cycles. A 6-bit down-counter runs 47 to 0.
  - Bit n is on DI for exactly one cycle.
  - After bit 0, go to HANDOFF.
- HANDOFF: DI=1, rp_start=1 for exactly one cycle. Load the timeout counter with 0, then go to WAIT.
- WAIT:
  - DI=1 and the counter increments each cycle.
  - If rp_finish=1: response<=rp_response, timeout<=0, go to DONE.
  - Else if the counter reaches TIMEOUT_CYC-1: response<=8'hFF, timeout<=1, go to DONE.
  - If rp_finish coincides with the last timeout cycle, rp_finish wins.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Latency: from the start-accept edge, the first frame bit is on DI after PRE_BYTES*8 cycles. rp_start is high on cycle PRE_BYTES*8+48.
- start while busy is ignored; there is no queuing. start held high in DONE is not accepted until IDLE.
- After a timeout the parser may be stalled in its wait-for-low state. The controller must reset the parser; this block does not.
- Undefined state encodings return to IDLE.

Decomposition:
- Shared package sd_pkg:
  - state encoding constants: IDLE, FILL, SEND, HANDOFF, WAIT, DONE
  - SD_START_BITS=2'b01
  - CRC7_POLY=7'h09
  - R1_TIMEOUT_VAL=8'hFF
  - command index constants CMD0, CMD8, CMD55, ACMD41
- One sub-module, sd_crc7: serial CRC7 with ports clk, rst, clr, en, din, crc[6:0]. It is reused later for data-path CRC checks.

Test Plan:
- CMD0, arg=0, PRE_BYTES=1:
  - DI shows 8 ones, then bytes 40 00 00 00 00 95.
  - rp_start pulses on cycle 56.
  - Model the parser returning 0x01 → done with response=0x01, timeout=0.
- CMD8, arg=32'h000001AA: frame bytes are 48 00 00 01 AA 87, checking CRC7=0x43.
- Timeout:
  - rp_finish never asserted, TIMEOUT_CYC=16.
  - done arrives exactly 16 cycles after rp_start with response=0xFF, timeout=1.
  - Separately, rp_finish on the final wait cycle → timeout=0.
- start pulsed mid-SEND with different cmd_index/arg: the transmitted frame is unchanged and no second frame follows.
- rst asserted during bit 20 of SEND:
  - next cycle DI=1, busy=0, rp_start=0, state=IDLE.
  - A following CMD0 transmits correctly.
- Back-to-back: start held high continuously → consecutive frames separated by FILL. A new frame is accepted only in IDLE after each done, and response updates per frame.
